// File: rtl/prog_loader_pkg.sv
// Shared state encoding and size constants for the instruction-memory program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CHK,
    DONE,
    ERR
  } loader_state_t;

  localparam int unsigned LOADER_MAX_BYTES = 512;
  localparam int unsigned LOADER_LEN_W     = 16;

endpackage

// File: rtl/prog_loader.sv
// Length-prefixed byte-stream loader that writes the instruction memory and then raises start.
// Optional trailing XOR checksum byte is enabled by defining PROG_LOADER_CHECKSUM_EN.
//
// state  | meaning
// IDLE   | after reset, waiting for load_req
// LEN_LO | expecting image length low byte
// LEN_HI | expecting image length high byte, length checked on acceptance
// DATA   | writing image bytes to consecutive addresses from 0
// CHK    | expecting the XOR checksum byte (checksum build only)
// DONE   | image complete, fetch released
// ERR    | bad length or checksum, held until the next load_req
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned MEM_BYTES = LOADER_MAX_BYTES,
  parameter int unsigned ADDR_W    = $clog2(MEM_BYTES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              start,
  output logic              busy,
  output logic              error
);

  localparam logic [LOADER_LEN_W-1:0] MAX_LEN = LOADER_LEN_W'(MEM_BYTES);
  localparam logic [ADDR_W:0]         CNT_MAX = (ADDR_W+1)'(MEM_BYTES);

  loader_state_t             state_q, state_d;
  logic [LOADER_LEN_W-1:0]   len_q, len_d;
  logic [ADDR_W:0]           cnt_q, cnt_d;
  logic                      mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]         mem_addr_q, mem_addr_d;
  logic [7:0]                mem_wdata_q, mem_wdata_d;
  logic                      ready_q, ready_d;
  logic                      busy_q, busy_d;
  logic                      start_q, start_d;
  logic                      error_q, error_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]                csum_q, csum_d;
`endif

  logic                      accept;
  logic                      last_byte;
  logic [LOADER_LEN_W-1:0]   len_new;
  logic [LOADER_LEN_W-1:0]   cnt_ext;

  assign accept    = in_valid && ready_q;
  assign len_new   = {in_data, len_q[7:0]};
  assign cnt_ext   = {{(LOADER_LEN_W-ADDR_W-1){1'b0}}, cnt_q};
  assign last_byte = (cnt_ext + LOADER_LEN_W'(1)) == len_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (load_req) begin
          state_d = LEN_LO;
          len_d   = '0;
          cnt_d   = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_d   = {8'h00, in_data};
          state_d = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_d   = len_new;
          state_d = (len_new == '0 || len_new > MAX_LEN) ? ERR : DATA;
        end
      end
      DATA: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = cnt_q[ADDR_W-1:0];
          mem_wdata_d = in_data;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + (ADDR_W+1)'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
          if (last_byte) state_d = CHK;
`else
          if (last_byte) state_d = DONE;
`endif
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CHK: begin
        if (accept) state_d = (in_data == csum_q) ? DONE : ERR;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they track the state register exactly.
  always_comb begin
    ready_d = state_d inside {LEN_LO, LEN_HI, DATA, CHK};
    busy_d  = state_d inside {LEN_LO, LEN_HI, DATA, CHK};
    start_d = state_d == DONE;
    error_d = state_d == ERR;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      start_q     <= start_d;
      error_q     <= error_d;
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) csum_q <= '0;
    else        csum_q <= csum_d;
  end
`endif

  assign in_ready  = ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign start     = start_q;
  assign busy      = busy_q;
  assign error     = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomised scoreboard bench for prog_loader; expected writes are queued as bytes are issued.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_req;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_we;
  logic [8:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       start;
  logic       busy;
  logic       error;

  typedef struct packed {
    logic [8:0] addr;
    logic [7:0] data;
  } wr_t;
  typedef logic [7:0] byte_q_t[$];

  wr_t exp_wr[$];
  wr_t mon_w;
  int  checks = 0;
  int  errors = 0;

  prog_loader dut (
    .clk       (clk),
    .reset     (reset),
    .load_req  (load_req),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .start     (start),
    .busy      (busy),
    .error     (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (reset === 1'b1 && mem_we === 1'b1) begin
      if (exp_wr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr=%0h data=%0h required=no write", mem_addr, mem_wdata);
      end else begin
        mon_w = exp_wr.pop_front();
        chk("wr_addr", {23'd0, mem_addr}, {23'd0, mon_w.addr});
        chk("wr_data", {24'd0, mem_wdata}, {24'd0, mon_w.data});
      end
    end
  end

  function automatic logic [7:0] xor_all(input byte_q_t d);
    logic [7:0] a = 8'h00;
    foreach (d[i]) a ^= d[i];
    return a;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
    int n = 0;
    int idle = int'($urandom_range(gap, 0));
    repeat (idle) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    load_req = poke;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      load_req = 1'b0;
      n++;
    end
    if (n >= 50) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      load_req = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    load_req = 1'b0;
    in_data  = 8'($urandom);
  endtask

  // Reference behaviour: length rule, writes at 0..L-1, XOR checksum when compiled in.
  task automatic do_load(input int len, input byte_q_t data, input logic [7:0] csum,
                         input int gap, input bit poke);
    logic [15:0] l16;
    bit          ok;
    l16 = len[15:0];
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    chk("req_ready", {31'd0, in_ready}, 32'd1);
    chk("req_busy",  {31'd0, busy},     32'd1);
    chk("req_start", {31'd0, start},    32'd0);
    chk("req_error", {31'd0, error},    32'd0);
    send_byte(l16[7:0], gap, 1'b0);
    send_byte(l16[15:8], gap, 1'b0);
    if (len == 0 || len > 512) begin
      ok = 1'b0;
    end else begin
      for (int k = 0; k < len; k++) begin
        wr_t w;
        w.addr = k[8:0];
        w.data = data[k];
        exp_wr.push_back(w);
        send_byte(data[k], gap, poke && ($urandom_range(3, 0) == 0));
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ok = (csum == xor_all(data));
      send_byte(csum, gap, 1'b0);
`else
      ok = 1'b1;
`endif
    end
    chk("end_start", {31'd0, start}, {31'd0, ok});
    chk("end_error", {31'd0, error}, {31'd0, !ok});
    chk("end_busy",  {31'd0, busy},  32'd0);
    in_valid = 1'b1;
    in_data  = csum;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("trail_ready", {31'd0, in_ready}, 32'd0);
    chk("trail_start", {31'd0, start}, {31'd0, ok});
    chk("sb_empty", exp_wr.size(), 32'd0);
    exp_wr.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"},  {31'd0, in_ready},  32'd0);
    chk({tag, "_mem_we"},    {31'd0, mem_we},    32'd0);
    chk({tag, "_mem_addr"},  {23'd0, mem_addr},  32'd0);
    chk({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
    chk({tag, "_start"},     {31'd0, start},     32'd0);
    chk({tag, "_busy"},      {31'd0, busy},      32'd0);
    chk({tag, "_error"},     {31'd0, error},     32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t img;
    byte_q_t rnd;
    byte_q_t none;
    int      len;
    logic [7:0] cs;

    reset    = 1'b0;
    load_req = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #3;
    chk_all_zero("rst");
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", {31'd0, in_ready}, 32'd0);

    img = '{8'h13, 8'h05, 8'h50, 8'h00};
    do_load(4, img, 8'h46, 0, 1'b0);
    do_load(4, img, 8'h46, 2, 1'b1);
    do_load(0, none, 8'h00, 0, 1'b0);
    do_load(513, none, 8'h00, 1, 1'b0);
`ifdef PROG_LOADER_CHECKSUM_EN
    do_load(4, img, 8'h47, 0, 1'b0);
`endif

    rnd.delete();
    for (int i = 0; i < 512; i++) rnd.push_back(8'($urandom));
    do_load(512, rnd, xor_all(rnd), 0, 1'b1);

    for (int it = 0; it < 20; it++) begin
      case ($urandom_range(7, 0))
        0: len = 0;
        1: len = 513;
        2: len = int'($urandom_range(65535, 514));
        3: len = 512;
        default: len = int'($urandom_range(40, 1));
      endcase
      rnd.delete();
      for (int i = 0; i < len && i < 512; i++) rnd.push_back(8'($urandom));
      cs = xor_all(rnd);
      if ($urandom_range(3, 0) == 0) cs = cs ^ 8'($urandom_range(255, 1));
      do_load(len, rnd, cs, int'($urandom_range(2, 0)), 1'b1);
    end

    // Abort after two of four data bytes, then reload cleanly.
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    send_byte(8'h04, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      wr_t w;
      w.addr = k[8:0];
      w.data = img[k];
      exp_wr.push_back(w);
      send_byte(img[k], 0, 1'b0);
    end
    #2 reset = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    exp_wr.delete();
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_idle_busy", {31'd0, busy}, 32'd0);
    do_load(4, img, 8'h46, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader that fills the core's 512-byte instruction memory and then releases the core to fetch. It accepts a length-prefixed byte stream over a valid/ready handshake, writes each byte into consecutive memory addresses from 0, and raises the `start` level consumed by the fetch stage once the image is complete. It is the writer side of the instruction memory, whose reader is the PC/instruction-fetch path.

## Interface
- `MEM_BYTES`, 512, instruction memory size in bytes; the maximum legal image length.
- `ADDR_W`, 9, memory byte-address width; equals $clog2(MEM_BYTES).
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-low reset.
- `load_req`  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- `in_valid`  input  1  stream byte valid.
- `in_data`  input  8  stream byte.
- `in_ready`  output  1  loader can accept a byte this cycle.
- `mem_we`  output  1  byte write strobe to instruction memory.
- `mem_addr`  output  ADDR_W  write byte address.
- `mem_wdata`  output  8  write data.
- `start`  output  1  level signal that releases the core's fetch stage.
- `busy`  output  1  a load is in progress.
- `error`  output  1  the last load failed; held until the next `load_req`.

## Operation
- A byte is accepted on any cycle with `in_valid && in_ready`.
- States and transitions:
  - IDLE, on `load_req`, goes to LEN_LO.
  - LEN_LO accepts the length low byte.
  - LEN_HI accepts the length high byte. The 16-bit length L is checked on acceptance: L == 0 or L > MEM_BYTES goes to ERR; otherwise to DATA.
  - DATA accepts L bytes. Byte k, for k = 0..L-1, is written to address k. After byte L-1 it goes to CHK if the checksum feature is compiled in, otherwise to DONE.
  - CHK accepts one checksum byte. A match goes to DONE; a mismatch goes to ERR.
  - DONE and ERR are terminal until the next `load_req`, which goes to LEN_LO.
- `in_ready` = 1 in LEN_LO, LEN_HI, DATA and CHK; 0 otherwise.
- `busy` = 1 in LEN_LO, LEN_HI, DATA and CHK.
- `start` = 1 only in DONE.
- `error` = 1 only in ERR.
- The address counter is ADDR_W+1 bits wide and saturates; it never wraps, because L ≤ MEM_BYTES.
- `load_req` during LEN_LO, LEN_HI, DATA or CHK is ignored.
- A new `load_req` in DONE drops `start` before any memory write, so the core never fetches from a partially rewritten image.
- Memory contents are never cleared by the loader.

## Timing
- Reset values: `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `start`=0, `busy`=0, `error`=0. State = IDLE; counters and checksum = 0.
- A reset assertion mid-load returns to IDLE immediately; outputs take their reset values asynchronously.
- `mem_we`, `mem_addr` and `mem_wdata` are registered. For a DATA byte accepted in cycle n, the write strobe is high in cycle n+1 with that byte's address and data. `mem_we` is a single-cycle pulse per byte.
- State outputs (`in_ready`, `busy`, `start`, `error`) are registered from state and change the cycle after the transition.
- `load_req` in cycle n puts the loader in LEN_LO, with `in_ready`=1 and `start`=0, in cycle n+1.
- Throughput is one byte per cycle with no bubbles. Minimum load time is L+2 accepted bytes, plus 1 for the checksum when enabled.
- After the last DATA byte, or the CHK byte, is accepted in cycle n, `start` rises in cycle n+1. The final `mem_we` is also in cycle n+1, so memory is complete by the first fetch edge.
- `in_valid` is permitted to deassert between bytes without effect. `in_data` is sampled only on acceptance.

## Configuration
- Macro: `PROG_LOADER_CHECKSUM_EN`.
- Defined:
  - A running XOR of all DATA bytes is kept.
  - One trailing checksum byte is required in CHK.
  - On mismatch the loader goes to ERR and `start` stays 0. Memory has already been written and is left as written.
- Undefined:
  - No CHK state and no accumulator.
  - DATA goes directly to DONE.
  - A checksum byte sent by the host is treated as unrelated stream data and is not consumed.

## Structure
- Shared package `loader_pkg` holds:
  - the state enum `loader_state_t` (IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR);
  - the localparam `LOADER_MAX_BYTES` = 512;
  - the length width constant (16).
- No sub-module: a single flat FSM with its counter, length register and checksum register.

## Test plan
- Stream 04 00 13 05 50 00 (plus 46 when the checksum feature is enabled) -> `mem_we` pulses at addresses 0..3 with data 13, 05, 50, 00; `start`=1 the cycle after the last byte; `error`=0.
- Length 00 00 -> ERR; `error`=1, no `mem_we`, `start`=0. Length 01 02 (513) -> ERR.
- Checksum feature enabled, same image with checksum 47 -> ERR; `start`=0; addresses 0..3 were written.
- `in_valid` toggled 1,0,0,1,... during DATA -> writes occur only on accepted cycles, with addresses contiguous 0..L-1.
- Reset asserted after 2 of 4 DATA bytes -> all outputs 0 at once. A subsequent `load_req` with a full stream completes normally.
- `load_req` in DONE -> `start` falls the next cycle and `busy`=1. `load_req` pulsed during DATA -> ignored; the byte count is unaffected.
